// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register writeback queue.
// Holds the machine word length, the default register file geometry,
// the writeback entry layout and the drain decision encoding.
package reg_writeback_queue_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int RWQ_SIZE    = 16;
  localparam int RWQ_ADDR_W  = $clog2(RWQ_SIZE);
  localparam int RWQ_DEPTH   = 8;

  typedef struct packed {
    logic [RWQ_ADDR_W-1:0]  addr;
    logic [WORD_LENGTH-1:0] data;
  } wb_entry_t;

  // What the drain side does this cycle: nothing, a single write,
  // two independent writes, or two same-address entries merged into one write.
  typedef enum logic [1:0] {
    DRAIN_NONE  = 2'd0,
    DRAIN_ONE   = 2'd1,
    DRAIN_PAIR  = 2'd2,
    DRAIN_MERGE = 2'd3
  } drain_mode_e;

endpackage

// File: rtl/reg_writeback_queue_wb_fifo_2in_2out.sv
// Circular buffer accepting 0-2 pushes and 0-2 pops per cycle.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push_cnt        number of entries written this cycle (push0 first, then push1)
//   push0, push1    entries to write at tail and tail+1
//   pop_cnt         number of entries removed from head this cycle
//   head0, head1    entries at head and head+1
//   count           occupied entries
//   head_ptr        index of the oldest entry
//   entries         raw storage, for the bypass scan in the parent
// The caller guarantees push/pop counts never overflow or underflow.
module wb_fifo_2in_2out
  import reg_writeback_queue_pkg::*;
#(
  parameter int  DEPTH = RWQ_DEPTH,
  parameter type T     = wb_entry_t
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              push_cnt,
  input  T                        push0,
  input  T                        push1,
  input  logic [1:0]              pop_cnt,
  output T                        head0,
  output T                        head1,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output T                        entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] tail_plus1;
  logic [PW-1:0] head_plus1;

  // Pointers are exactly log2(DEPTH) bits wide, so +1 wraps DEPTH-1 -> 0 for free.
  assign tail_plus1 = tail_q + PW'(1);
  assign head_plus1 = head_q + PW'(1);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q + PW'(pop_cnt);
    tail_d  = tail_q + PW'(push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    if (push_cnt != 2'd0) mem_d[tail_q] = push0;
    if (push_cnt == 2'd2) mem_d[tail_plus1] = push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head0    = mem_q[head_q];
  assign head1    = mem_q[head_plus1];
  assign count    = count_q;
  assign head_ptr = head_q;
  assign entries  = mem_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-side front end for the 2-write-port register file.
// Buffers results from producer A (ALU) and producer B (memory) in order,
// drains up to two per cycle onto the register file write ports and offers
// a bypass lookup over buffered entries.
// Ports:
//   clk, rst                      clock and asynchronous active-low reset
//   aValid/aReady/aAddr/aData     producer A handshake and payload (A is older)
//   bValid/bReady/bAddr/bData     producer B handshake and payload
//   drainEn                       register file may be written this cycle
//   writeEnable1/Addr1/Data1      write port 1 (wins on equal addresses)
//   writeEnable2/Addr2/Data2      write port 2
//   lookupAddr/lookupHit/lookupData  bypass query, youngest buffered match
//   count, empty                  occupancy
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int SIZE  = RWQ_SIZE,
  parameter int WIDTH = WORD_LENGTH,
  parameter int DEPTH = RWQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    aValid,
  output logic                    aReady,
  input  logic [$clog2(SIZE)-1:0] aAddr,
  input  logic [WIDTH-1:0]        aData,
  input  logic                    bValid,
  output logic                    bReady,
  input  logic [$clog2(SIZE)-1:0] bAddr,
  input  logic [WIDTH-1:0]        bData,
  input  logic                    drainEn,
  output logic                    writeEnable1,
  output logic [$clog2(SIZE)-1:0] writeAddr1,
  output logic [WIDTH-1:0]        writeData1,
  output logic                    writeEnable2,
  output logic [$clog2(SIZE)-1:0] writeAddr2,
  output logic [WIDTH-1:0]        writeData2,
  input  logic [$clog2(SIZE)-1:0] lookupAddr,
  output logic                    lookupHit,
  output logic [WIDTH-1:0]        lookupData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic          ready;
  logic          a_fire;
  logic          b_fire;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  entry_t        a_entry;
  entry_t        b_entry;
  entry_t        push0;
  entry_t        head0;
  entry_t        head1;
  logic [PW-1:0] head_ptr;
  entry_t        fifo_entries [DEPTH];
  drain_mode_e   drain_mode;
  logic [PW-1:0] scan_idx;

  wb_fifo_2in_2out #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (b_entry),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (count),
    .head_ptr (head_ptr),
    .entries  (fifo_entries)
  );

  // Ready needs room for a full pair and looks only at the registered count,
  // so it never depends on valid or on this cycle's drain.
  assign ready  = (count <= CW'(DEPTH - 2));
  assign aReady = ready;
  assign bReady = ready;
  assign empty  = (count == '0);

  assign a_fire   = aValid & ready;
  assign b_fire   = bValid & ready;
  assign a_entry  = '{addr: aAddr, data: aData};
  assign b_entry  = '{addr: bAddr, data: bData};
  assign push_cnt = {1'b0, a_fire} + {1'b0, b_fire};
  // A lone B transfer still lands at tail, so B moves into the first slot.
  assign push0    = a_fire ? a_entry : b_entry;

  // Decide how the head pair leaves the queue this cycle.
  always_comb begin
    drain_mode = DRAIN_NONE;
    if (drainEn) begin
      if (count == CW'(1)) begin
        drain_mode = DRAIN_ONE;
      end else if (count >= CW'(2)) begin
        drain_mode = (head0.addr == head1.addr) ? DRAIN_MERGE : DRAIN_PAIR;
      end
    end
  end

  // On a same-address pair the older value would be overwritten anyway,
  // so only the newer one is written and both entries are popped.
  always_comb begin
    writeEnable1 = 1'b0;
    writeAddr1   = head0.addr;
    writeData1   = head0.data;
    writeEnable2 = 1'b0;
    writeAddr2   = head1.addr;
    writeData2   = head1.data;
    pop_cnt      = 2'd0;
    unique case (drain_mode)
      DRAIN_ONE: begin
        writeEnable1 = 1'b1;
        pop_cnt      = 2'd1;
      end
      DRAIN_PAIR: begin
        writeEnable1 = 1'b1;
        writeEnable2 = 1'b1;
        pop_cnt      = 2'd2;
      end
      DRAIN_MERGE: begin
        writeEnable1 = 1'b1;
        writeAddr1   = head1.addr;
        writeData1   = head1.data;
        pop_cnt      = 2'd2;
      end
      default: begin
      end
    endcase
  end

  // Scan from oldest to youngest; a later match overrides an earlier one,
  // leaving the entry closest to tail. Only occupied slots take part.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    scan_idx   = head_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PW'(k);
      if ((CW'(k) < count) && (fifo_entries[scan_idx].addr == lookupAddr)) begin
        lookupHit  = 1'b1;
        lookupData = fifo_entries[scan_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int W     = 32;

  logic          clk;
  logic          rst;
  logic          aValid, aReady, bValid, bReady;
  logic [AW-1:0] aAddr, bAddr;
  logic [W-1:0]  aData, bData;
  logic          drainEn;
  logic          writeEnable1, writeEnable2;
  logic [AW-1:0] writeAddr1, writeAddr2;
  logic [W-1:0]  writeData1, writeData2;
  logic [AW-1:0] lookupAddr;
  logic          lookupHit;
  logic [W-1:0]  lookupData;
  logic [3:0]    count;
  logic          empty;

  reg_writeback_queue #(.SIZE(16), .WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .aValid       (aValid),
    .aReady       (aReady),
    .aAddr        (aAddr),
    .aData        (aData),
    .bValid       (bValid),
    .bReady       (bReady),
    .bAddr        (bAddr),
    .bData        (bData),
    .drainEn      (drainEn),
    .writeEnable1 (writeEnable1),
    .writeAddr1   (writeAddr1),
    .writeData1   (writeData1),
    .writeEnable2 (writeEnable2),
    .writeAddr2   (writeAddr2),
    .writeData2   (writeData2),
    .lookupAddr   (lookupAddr),
    .lookupHit    (lookupHit),
    .lookupData   (lookupData),
    .count        (count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } ent_t;

  ent_t model_q[$];
  int   checks = 0;
  int   errors = 0;
  int   expPop;
  bit   expReady;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic aV, input logic [AW-1:0] aA, input logic [W-1:0] aD,
                               input logic bV, input logic [AW-1:0] bA, input logic [W-1:0] bD,
                               input logic dEn, input logic [AW-1:0] lk);
    @(negedge clk);
    aValid = aV; aAddr = aA; aData = aD;
    bValid = bV; bAddr = bA; bData = bD;
    drainEn = dEn; lookupAddr = lk;
    #1;
  endtask

  // Compare every output with what the queue model says for the current inputs.
  task automatic checkOutput(input string tag);
    int   n;
    logic eW1, eW2, eHit;
    ent_t p1, p2;
    logic [W-1:0] eData;
    n = model_q.size();
    expReady = (DEPTH - n) >= 2;
    eW1 = 1'b0; eW2 = 1'b0; expPop = 0;
    p1 = '{addr: '0, data: '0};
    p2 = '{addr: '0, data: '0};
    if (drainEn && n == 1) begin
      eW1 = 1'b1; p1 = model_q[0]; expPop = 1;
    end else if (drainEn && n >= 2) begin
      expPop = 2;
      eW1 = 1'b1;
      if (model_q[0].addr == model_q[1].addr) begin
        p1 = model_q[1];
      end else begin
        eW2 = 1'b1; p1 = model_q[0]; p2 = model_q[1];
      end
    end
    eHit = 1'b0; eData = '0;
    foreach (model_q[i]) if (model_q[i].addr == lookupAddr) begin
      eHit = 1'b1; eData = model_q[i].data;
    end
    chk({tag, ".count"}, count, n);
    chk({tag, ".empty"}, empty, n == 0);
    chk({tag, ".aReady"}, aReady, expReady);
    chk({tag, ".bReady"}, bReady, expReady);
    chk({tag, ".we1"}, writeEnable1, eW1);
    if (eW1) begin
      chk({tag, ".addr1"}, writeAddr1, p1.addr);
      chk({tag, ".data1"}, writeData1, p1.data);
    end
    chk({tag, ".we2"}, writeEnable2, eW2);
    if (eW2) begin
      chk({tag, ".addr2"}, writeAddr2, p2.addr);
      chk({tag, ".data2"}, writeData2, p2.data);
    end
    chk({tag, ".hit"}, lookupHit, eHit);
    if (eHit) chk({tag, ".ldata"}, lookupData, eData);
  endtask

  // Advance through the rising edge and apply the same transfer to the model.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    repeat (expPop) void'(model_q.pop_front());
    if (aValid && expReady) begin e.addr = aAddr; e.data = aData; model_q.push_back(e); end
    if (bValid && expReady) begin e.addr = bAddr; e.data = bData; model_q.push_back(e); end
  endtask

  task automatic step(input string tag,
                      input logic aV, input logic [AW-1:0] aA, input logic [W-1:0] aD,
                      input logic bV, input logic [AW-1:0] bA, input logic [W-1:0] bD,
                      input logic dEn, input logic [AW-1:0] lk);
    applyStimulus(aV, aA, aD, bV, bA, bD, dEn, lk);
    checkOutput(tag);
    tick();
  endtask

  logic          aPend, bPend, dRand;
  logic [AW-1:0] pA, pB, lRand;
  logic [W-1:0]  dA, dB;

  initial begin
    rst = 1'b0;
    aValid = 0; aAddr = '0; aData = '0;
    bValid = 0; bAddr = '0; bData = '0;
    drainEn = 0; lookupAddr = '0;
    #1;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.we1", writeEnable1, 0);
    chk("rst.we2", writeEnable2, 0);
    chk("rst.hit", lookupHit, 0);
    chk("rst.aReady", aReady, 1);
    chk("rst.bReady", bReady, 1);
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset released");

    // Dual enqueue then drain both on separate ports.
    step("dual.enq", 1, 4'd3, 32'h11111111, 1, 4'd5, 32'h22222222, 0, 4'd0);
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd5);
    checkOutput("dual.drain");
    chk("dual.count2", count, 2);
    chk("dual.a1", writeAddr1, 3);
    chk("dual.d1", writeData1, 32'h11111111);
    chk("dual.a2", writeAddr2, 5);
    chk("dual.d2", writeData2, 32'h22222222);
    tick();
    step("dual.after", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd3);

    // Same-address pair collapses into one write of the newer data.
    step("coll.enq", 1, 4'd7, 32'hAAAA0000, 1, 4'd7, 32'hBBBB0000, 0, 4'd7);
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd7);
    checkOutput("coll.drain");
    chk("coll.we1", writeEnable1, 1);
    chk("coll.a1", writeAddr1, 7);
    chk("coll.d1", writeData1, 32'hBBBB0000);
    chk("coll.we2", writeEnable2, 0);
    chk("coll.ldata", lookupData, 32'hBBBB0000);
    tick();
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd7);
    checkOutput("coll.after");
    chk("coll.count0", count, 0);
    tick();

    // Bypass returns the youngest match; same-cycle producer data does not hit.
    step("byp.enq1", 1, 4'd4, 32'h1, 1, 4'd9, 32'h2, 0, 4'd4);
    step("byp.enq2", 1, 4'd4, 32'h3, 0, 4'd0, 32'h0, 0, 4'd4);
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd4);
    checkOutput("byp.q4");
    chk("byp.hit4", lookupHit, 1);
    chk("byp.data4", lookupData, 32'h3);
    tick();
    applyStimulus(1, 4'd2, 32'h55, 0, 4'd0, 32'h0, 0, 4'd2);
    checkOutput("byp.q2");
    chk("byp.hit2", lookupHit, 0);
    tick();
    step("byp.drain1", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd2);
    step("byp.drain2", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd2);

    // Odd count: a pair then a single.
    step("odd.enq1", 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 4'd0);
    step("odd.enq2", 1, 4'd3, 32'hC3, 0, 4'd0, 32'h0, 0, 4'd0);
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd0);
    checkOutput("odd.c1");
    chk("odd.c1we1", writeEnable1, 1);
    chk("odd.c1we2", writeEnable2, 1);
    tick();
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd0);
    checkOutput("odd.c2");
    chk("odd.c2we1", writeEnable1, 1);
    chk("odd.c2a1", writeAddr1, 3);
    chk("odd.c2we2", writeEnable2, 0);
    tick();
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);
    checkOutput("odd.after");
    chk("odd.empty", empty, 1);
    tick();

    // Fill to 7 with draining off, hold a pair under backpressure, then drain with wrap.
    step("full.e0", 1, 4'd0, 32'hF0, 0, 4'd0, 32'h0, 0, 4'd0);
    for (int i = 0; i < 3; i++)
      step("full.pair", 1, 4'(2*i+1), 32'hF00 + W'(i), 1, 4'(2*i+2), 32'hE00 + W'(i), 0, 4'd1);
    aPend = 1; pA = 4'd8; dA = 32'hFEED0008;
    bPend = 1; pB = 4'd9; dB = 32'hFEED0009;
    applyStimulus(aPend, pA, dA, bPend, pB, dB, 0, 4'd8);
    checkOutput("full.c7");
    chk("full.count7", count, 7);
    chk("full.aReady0", aReady, 0);
    chk("full.bReady0", bReady, 0);
    tick();
    step("full.hold", aPend, pA, dA, bPend, pB, dB, 0, 4'd8);
    for (int i = 0; i < 10; i++) begin
      if (!aPend) begin aPend = 1'($urandom_range(0, 1)); pA = 4'($urandom); dA = $urandom; end
      if (!bPend) begin bPend = 1'($urandom_range(0, 1)); pB = 4'($urandom); dB = $urandom; end
      step("wrap", aPend, pA, dA, bPend, pB, dB, 1, 4'd8);
      if (expReady) begin aPend = 0; bPend = 0; end
    end

    // Randomized traffic; a small address range makes collisions and bypass hits common.
    for (int i = 0; i < 400; i++) begin
      if (!aPend) begin aPend = 1'($urandom_range(0, 1)); pA = 4'($urandom_range(0, 5)); dA = $urandom; end
      if (!bPend) begin bPend = 1'($urandom_range(0, 1)); pB = 4'($urandom_range(0, 5)); dB = $urandom; end
      dRand = ($urandom_range(0, 9) < 6);
      lRand = 4'($urandom_range(0, 6));
      step("rand", aPend, pA, dA, bPend, pB, dB, dRand, lRand);
      if (expReady) begin aPend = 0; bPend = 0; end
    end

    // Reset mid-operation with draining active.
    for (int i = 0; i < 8 && model_q.size() > 0; i++)
      step("flush", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd0);
    step("mid.e1", 1, 4'd1, 32'h101, 1, 4'd2, 32'h102, 0, 4'd1);
    step("mid.e2", 1, 4'd3, 32'h103, 1, 4'd4, 32'h104, 0, 4'd1);
    step("mid.e3", 1, 4'd5, 32'h105, 0, 4'd0, 32'h0, 0, 4'd1);
    applyStimulus(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd1);
    checkOutput("mid.pre");
    chk("mid.pre.count5", count, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.count", count, 0);
    chk("mid.empty", empty, 1);
    chk("mid.we1", writeEnable1, 0);
    chk("mid.we2", writeEnable2, 0);
    chk("mid.hit", lookupHit, 0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    drainEn = 1'b0;
    #1;
    chk("mid.aReady", aReady, 1);
    chk("mid.bReady", bReady, 1);
    step("mid.resume", 1, 4'd6, 32'h106, 0, 4'd0, 32'h0, 0, 4'd6);
    step("mid.check", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side front end for the 2-write-port register file (port 1 has priority on equal addresses).
- Collects writeback results from two producers: A (ALU path) and B (memory path).
- Buffers them in order and drains up to two per cycle onto the register file write ports, resolving same-address collisions in favour of the newer result.
- Provides a bypass lookup so readers see buffered, not-yet-written values.

Parameters:
- SIZE, 16, number of architectural registers; address width is clog2(SIZE).
- WIDTH, WORD_LENGTH, data width.
- DEPTH, 8, queue entries; power of two, minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- aValid  in  1  producer A has a result.
- aReady  out  1  queue accepts producer A this cycle.
- aAddr  in  clog2(SIZE)  producer A target register.
- aData  in  WIDTH  producer A data.
- bValid  in  1  producer B has a result.
- bReady  out  1  queue accepts producer B this cycle.
- bAddr  in  clog2(SIZE)  producer B target register.
- bData  in  WIDTH  producer B data.
- drainEn  in  1  register file may be written this cycle.
- writeEnable1  out  1  register file write port 1 enable.
- writeAddr1  out  clog2(SIZE)  write port 1 address.
- writeData1  out  WIDTH  write port 1 data.
- writeEnable2  out  1  register file write port 2 enable.
- writeAddr2  out  clog2(SIZE)  write port 2 address.
- writeData2  out  WIDTH  write port 2 data.
- lookupAddr  in  clog2(SIZE)  bypass query address.
- lookupHit  out  1  a buffered entry targets lookupAddr.
- lookupData  out  WIDTH  data of the youngest matching entry.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Storage: circular buffer with head and tail pointers that wrap modulo DEPTH, plus a count register.
- Reset (rst low, asynchronous): head = tail = count = 0, all entries invalid, empty = 1.
  - Outputs at reset: writeEnable1/2 = 0, lookupHit = 0, aReady = bReady = 1.
  - Any in-flight producer transfer in that cycle is discarded.
- Ready rule:
  - aReady = bReady = (DEPTH - count >= 2).
  - Based only on count at the start of the cycle; same-cycle drains do not raise ready.
  - Ready is independent of valid, so there is no combinational valid-to-ready path.
- Enqueue:
  - A transfer occurs when valid && ready.
  - If both A and B transfer, A is written at tail, B at tail+1, and tail advances by 2. A is defined older than B.
  - If only one transfers, it is written at tail and tail advances by 1.
- Drain (combinational outputs from head, head+1):
  - drainEn = 0 or count == 0: both enables 0; no pop.
  - count == 1: writeEnable1 = 1 with the head entry; writeEnable2 = 0; pop 1.
  - count >= 2, addresses differ: port 1 = head, port 2 = head+1, both enables 1; pop 2.
  - count >= 2, addresses equal: port 1 = head+1 (the newer entry), writeEnable2 = 0; pop 2. The older value is dropped.
  - A pop takes effect at the clock edge, in the same cycle the register file writes.
- Count update each edge: count + enq - pop, where enq and pop are each 0–2. Simultaneous enqueue and drain is legal. Count never exceeds DEPTH by construction of the ready rule.
- Bypass:
  - lookupHit / lookupData are combinational over the valid entries only.
  - The youngest match (closest to tail) wins.
  - Entries being drained in the current cycle still hit; same-cycle incoming producer data does not.
- Pointer wrap: an entry pair spanning DEPTH-1 → 0 behaves identically to a contiguous pair.
- Valid, addr and data are sampled only on a transfer. Producers hold their values while valid && !ready.

Decomposition:
- WORD_LENGTH comes from the shared defines.
- Add to the shared package:
  - a writeback entry struct {addr, data};
  - a localparam for the address width derived from SIZE.
- One natural sub-module: wb_fifo_2in_2out. It holds storage, pointers and count, with 0–2 push and 0–2 pop per cycle and exposes entries for the lookup scan.
- Collision resolution, ready logic and bypass scan stay in the top module.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill 5 entries, drop rst asynchronously mid-cycle.
  - Response: count = 0, empty = 1, writeEnable1/2 = 0 immediately; aReady = bReady = 1 after release.
- Dual enqueue and drain:
  - Stimulus: drainEn = 0; A {3, 0x11111111} and B {5, 0x22222222} in the same cycle; then drainEn = 1.
  - Response: next cycle count = 2; then writeEnable1 with addr 3 / 0x11111111 and writeEnable2 with addr 5 / 0x22222222; count returns to 0.
- Same-address collision:
  - Stimulus: A {7, 0xAAAA0000}, B {7, 0xBBBB0000}, then drain.
  - Response: writeEnable1 = 1, addr 7, data 0xBBBB0000; writeEnable2 = 0; count goes to 0.
- Full, backpressure and wrap:
  - Stimulus: drainEn = 0 with DEPTH = 8; enqueue pairs until count = 7.
  - Response: aReady = bReady = 0 at count 7; held A data is not lost.
  - Then drainEn = 1 for 10 cycles while enqueueing: pointers wrap, data emerges in FIFO order, count never exceeds 8.
- Bypass youngest wins:
  - Stimulus: queue {4, 0x1}, {9, 0x2}, {4, 0x3}; lookupAddr = 4.
  - Response: lookupHit = 1, lookupData = 0x3; lookupAddr = 2 gives lookupHit = 0.
- Odd count drain:
  - Stimulus: queue exactly 3 entries with distinct addresses, drainEn = 1.
  - Response: cycle 1 writes 2 entries on ports 1/2; cycle 2 writes only port 1; empty = 1 after.
